// File: rtl/dpu_pkg.sv
// Shared types and width helpers for the multiply-accumulate data path.
package dpu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Index width for a DEPTH-element word; a single element still needs one bit.
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One result element is twice the operand width.
  function automatic int unsigned elem_w(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/result_unloader_piso.sv
// Parallel-in serial-out element shifter: mirror of sipo on the fill side.
module piso
  import dpu_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MAX_NUM = 4,
  localparam int unsigned IDXW   = idx_w(MAX_NUM)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [WIDTH*MAX_NUM-1:0]   load_data,
  input  logic                       shift,
  output logic [WIDTH-1:0]           dout_serial,
  output logic [IDXW-1:0]            idx,
  output logic                       last
);

  logic [WIDTH*MAX_NUM-1:0] shadow;

  // Capture a whole word or step one element toward the output slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      idx    <= '0;
    end else if (load) begin
      shadow <= load_data;
      idx    <= '0;
    end else if (shift) begin
      shadow <= shadow >> WIDTH;
      idx    <= idx + 1'b1;
    end
  end

  assign dout_serial = shadow[WIDTH-1:0];
  assign last        = (idx == IDXW'(MAX_NUM - 1));

endmodule

// File: rtl/result_unloader.sv
// Drain side of the MAC path: captures a parallel result word and replays
// it one element per beat on a valid/ready stream.
module result_unloader
  import dpu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FCNT_W = 16,
  localparam int unsigned EW    = elem_w(WIDTH),
  localparam int unsigned IDXW  = idx_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [EW*DEPTH-1:0]   din_parallel,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [EW-1:0]         dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [IDXW-1:0]       dout_idx,
  output logic                  dout_last,
  output logic                  busy,
  output logic                  done,
  output logic [FCNT_W-1:0]     frame_cnt,
  output logic                  drop_err,
  input  logic                  clr_err
);

  state_t          state;
  logic            din_valid_q;
  logic            new_word;
  logic            load;
  logic            shift;
  logic            elem_last;
  logic [IDXW-1:0] idx;

  // din_valid_q clears on reset so a level held through reset release is a new word.
  assign new_word = din_valid & ~din_valid_q;
  assign load     = (state == IDLE) & new_word;
  assign shift    = (state == SEND) & dout_ready & ~elem_last;

  piso #(
    .WIDTH   (EW),
    .MAX_NUM (DEPTH)
  ) u_piso (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_data   (din_parallel),
    .shift       (shift),
    .dout_serial (dout),
    .idx         (idx),
    .last        (elem_last)
  );

  // Frame sequencing, completion pulse/count and sticky overlap error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      din_valid_q <= 1'b0;
      done        <= 1'b0;
      frame_cnt   <= '0;
      drop_err    <= 1'b0;
    end else begin
      din_valid_q <= din_valid;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (new_word) state <= SEND;
        end
        SEND: begin
          if (dout_ready && elem_last) begin
            state     <= IDLE;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (new_word && state == SEND) drop_err <= 1'b1;
      else if (clr_err)              drop_err <= 1'b0;
    end
  end

  assign din_ready  = (state == IDLE);
  assign busy       = (state == SEND);
  assign dout_valid = (state == SEND);
  assign dout_idx   = idx;
  // idx is left at DEPTH-1 after a frame; last is only meaningful while sending.
  assign dout_last  = (state == SEND) & elem_last;

endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Drain side of the multiply-accumulate data path.
- Captures the DEPTH-element parallel result word, each element 2*WIDTH bits, when the producer raises its valid.
- Replays the word one element per beat on a valid/ready stream toward memory/host, tagged with element index and last flag.
- Tracks completed frames and flags result words that arrive while a drain is still in progress.

Parameters:
WIDTH, 8, operand width; one element = 2*WIDTH bits
DEPTH, 4, elements per parallel word (>=1)
FCNT_W, 16, width of completed-frame counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
din_parallel  input  2*WIDTH*DEPTH  result word; element k at bits [2*WIDTH*(k+1)-1 : 2*WIDTH*k]
din_valid  input  1  producer valid (level; may stay high several cycles)
din_ready  output  1  high when a new word can be captured (state IDLE)
dout  output  2*WIDTH  current element
dout_valid  output  1  element valid
dout_ready  input  1  downstream ready
dout_idx  output  IDXW  element index, 0..DEPTH-1; IDXW = (DEPTH>1) ? $clog2(DEPTH) : 1
dout_last  output  1  high with element DEPTH-1
busy  output  1  high in SEND
done  output  1  one-cycle pulse after the last element handshake
frame_cnt  output  FCNT_W  completed frames; wraps at 2^FCNT_W
drop_err  output  1  sticky: a word arrived while busy
clr_err  input  1  clears drop_err

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, shadow register=0, idx=0, din_valid_q=0, dout_valid=0, dout=0, dout_idx=0, dout_last=0, busy=0, done=0, frame_cnt=0, drop_err=0. Reset mid-frame aborts the drain; no done pulse and no frame_cnt increment.
- new_word = din_valid & ~din_valid_q, where din_valid_q is din_valid registered. A level held high across reset release counts as a new word.
- FSM, two states:
  - IDLE: din_ready=1, dout_valid=0. On new_word, latch din_parallel into the shadow register, idx<=0, go to SEND.
  - SEND: dout_valid=1, dout=shadow[2W-1:0], dout_idx=idx, dout_last=(idx==DEPTH-1).
    - Handshake = dout_valid & dout_ready.
    - On a handshake that is not last: shadow shifts right by 2*WIDTH (zero fill), idx++.
    - On a last handshake: go to IDLE, done<=1 next cycle, frame_cnt++.
- Latency: new_word sampled at edge N puts element 0 valid in cycle N+1. With dout_ready tied high, one frame takes DEPTH cycles in SEND plus 1 cycle in IDLE.
- Stalls: while dout_ready=0, dout, dout_idx and dout_last hold stable. dout_valid never drops without a handshake.
- Back-to-back frames: the cycle after the last handshake is IDLE, so a new_word there is captured and element 0 appears on the following cycle.
- Overlap: new_word while in SEND is not captured and sets drop_err. The current frame continues unaffected. drop_err stays set until clr_err=1. If set and clear occur in the same cycle, set wins.
- DEPTH=1: every element is last; idx stays 0.
- frame_cnt wraps from 2^FCNT_W-1 to 0 with no flag.
- Elements are unsigned; no arithmetic is applied, data passes bit-exact.

Decomposition:
- Package dpu_pkg:
  - state enum {IDLE, SEND} as logic [0:0]
  - IDXW derivation as a function idx_w(depth)
  - element-width localparam helper (2*WIDTH)
- Natural sub-module: piso, the mirror of the existing sipo.
  - Parameters WIDTH (element width), MAX_NUM.
  - Ports: load, load_data, shift, dout_serial, idx, last.
- result_unloader holds the FSM, edge detect, done/frame_cnt/drop_err logic and the piso instance.

Test Plan (WIDTH=8, DEPTH=4):
- Basic drain: din_parallel={16'h0004,16'h0003,16'h0002,16'h0001}, one-cycle din_valid pulse, dout_ready=1 -> dout 0001,0002,0003,0004 on consecutive cycles starting 1 cycle after capture; dout_idx 0..3; dout_last only on 0004; done pulse 1 cycle after; frame_cnt=1.
- Backpressure: same word, dout_ready=0 for 3 cycles on element 0002 -> dout=0002, idx=1 held for 3 cycles, no element lost or duplicated; sequence completes; frame_cnt=1.
- Level valid and overlap: din_valid held high 10 cycles, then low, then a second rising edge during SEND of the next frame -> exactly one capture from the long level; drop_err=1 after the second edge; clr_err=1 -> drop_err=0; frame data unaffected.
- Back-to-back: second word {16'hFFFF,16'h8000,16'h00FF,16'h1234} raised in the IDLE cycle after frame 1's last handshake -> 1234,00FF,8000,FFFF follow with a 1-cycle gap; frame_cnt=2; drop_err stays 0.
- Reset mid-frame: rst=1 after element 0001 handshake -> next cycle dout_valid=0, busy=0, frame_cnt=0, no done pulse; a new word after reset drains from idx 0.
